// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, zero-register index and word/address types for the register file.
package regfile_pkg;
    localparam int WIDTH_DEFAULT  = 64;
    localparam int NREGS_DEFAULT  = 32;
    localparam int ADDR_W_DEFAULT = 5;
    localparam int ZERO_REG       = NREGS_DEFAULT - 1;
    typedef logic [WIDTH_DEFAULT-1:0]  word_t;
    typedef logic [ADDR_W_DEFAULT-1:0] regaddr_t;
endpackage

// File: rtl/mux_n.sv
// mux_n: parameterised N:1 multiplexer of W-bit words.
module mux_n #(
    parameter int N  = 32,
    parameter int W  = 64,
    parameter int SW = 5
) (
    input  logic [W-1:0]  i_d [N],
    input  logic [SW-1:0] i_sel,
    output logic [W-1:0]  o_y
);
    assign o_y = i_d[i_sel];
endmodule

// File: rtl/regfile_dec.sv
// regfile_dec: enable-gated 5:32 one-hot decoder tree built from a 2:4 stage feeding four 3:8 stages.
module dec2to4 (
    input  logic       i_en,
    input  logic [1:0] i_a,
    output logic [3:0] o_y
);
    assign o_y = i_en ? 4'b0001 << i_a : 4'b0000;
endmodule

module dec3to8 (
    input  logic       i_en,
    input  logic [2:0] i_a,
    output logic [7:0] o_y
);
    assign o_y = i_en ? 8'b0000_0001 << i_a : 8'b0000_0000;
endmodule

module regfile_dec (
    input  logic        i_en,
    input  logic [4:0]  i_a,
    output logic [31:0] o_y
);
    logic [3:0] w_grp;
    dec2to4 u_hi (.i_en(i_en), .i_a(i_a[4:3]), .o_y(w_grp));
    for (genvar g = 0; g < 4; g++) begin : g_lo
        dec3to8 u_lo (.i_en(w_grp[g]), .i_a(i_a[2:0]), .o_y(o_y[8*g +: 8]));
    end
endmodule

// File: rtl/regword.sv
// regword: one register with load enable and synchronous reset (flip-flops behind a 2:1 hold mux).
module regword #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_d;
    assign w_d = i_en ? i_d : r_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_q <= '0;
        else       r_q <= w_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/regfile.sv
// regfile: NREGS x WIDTH register file, one decoded write port, two combinational read ports,
// top register hard-wired to zero.
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);
    localparam int ZR = NREGS - 1;
    logic [NREGS-1:0] w_strobe;
    logic [WIDTH-1:0] w_regs [NREGS];

    regfile_dec u_dec (.i_en(RegWrite), .i_a(WriteRegister), .o_y(w_strobe));

    // The zero register has no storage; its strobe is simply ignored.
    for (genvar i = 0; i < ZR; i++) begin : g_reg
        regword #(.WIDTH(WIDTH)) u_word (
            .i_clk(clk), .i_rst(reset), .i_en(w_strobe[i]), .i_d(WriteData), .o_q(w_regs[i])
        );
    end
    assign w_regs[ZR] = '0;

    mux_n #(.N(NREGS), .W(WIDTH), .SW(ADDR_W)) u_rd1 (.i_d(w_regs), .i_sel(ReadRegister1), .o_y(ReadData1));
    mux_n #(.N(NREGS), .W(WIDTH), .SW(ADDR_W)) u_rd2 (.i_d(w_regs), .i_sel(ReadRegister2), .o_y(ReadData2));

    a_wr_addr_known: assert property (@(posedge clk) RegWrite |-> !$isunknown(WriteRegister));
    a_strobe_onehot: assert property (@(posedge clk) $onehot0(w_strobe));
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and randomized checks of regfile against an array model of the registers.
module tb_regfile;
    import regfile_pkg::*;
    logic     clk = 1'b0;
    logic     reset = 1'b0;
    logic     RegWrite = 1'b0;
    regaddr_t WriteRegister = '0;
    word_t    WriteData = '0;
    regaddr_t ReadRegister1 = '0;
    regaddr_t ReadRegister2 = '0;
    word_t    ReadData1, ReadData2;
    word_t    m [NREGS_DEFAULT];
    int       n_chk = 0;
    int       n_fail = 0;

    regfile dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, applying the architectural update rule to the model.
    task automatic step();
        @(posedge clk);
        if (reset) foreach (m[i]) m[i] = '0;
        else if (RegWrite && int'(WriteRegister) != ZERO_REG) m[WriteRegister] = WriteData;
        #1;
    endtask

    task automatic rd(input string tag, input int a1, input int a2);
        ReadRegister1 = regaddr_t'(a1);
        ReadRegister2 = regaddr_t'(a2);
        #1;
        check({tag, "_p1"}, ReadData1, m[a1]);
        check({tag, "_p2"}, ReadData2, m[a2]);
    endtask

    initial begin
        foreach (m[i]) m[i] = 'x;
        #1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NREGS_DEFAULT; i++) rd("reset", i, i);

        RegWrite = 1'b1;
        for (int i = 0; i < ZERO_REG; i++) begin
            WriteRegister = regaddr_t'(i);
            WriteData = word_t'(i) * 64'h0101_0101_0101_0101;
            step();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < NREGS_DEFAULT; i++) rd("sweep", i, ZERO_REG - i);
        rd("r30_const", 30, 30);
        check("r30_value", ReadData1, 64'h1E1E_1E1E_1E1E_1E1E);

        RegWrite = 1'b1; WriteRegister = regaddr_t'(ZERO_REG); WriteData = '1;
        step();
        RegWrite = 1'b0;
        rd("zero_reg", ZERO_REG, ZERO_REG);
        check("zero_reg_const", ReadData1, 64'h0);
        for (int i = 0; i < ZERO_REG; i++) rd("after_zero", i, i);

        RegWrite = 1'b0; WriteRegister = 5'd5; WriteData = 64'hDEAD_BEEF_0000_0001;
        step();
        rd("gate_off", 5, 5);
        check("gate_off_const", ReadData1, 64'h0505_0505_0505_0505);
        RegWrite = 1'b1;
        step();
        RegWrite = 1'b0;
        rd("gate_on", 5, 5);
        check("gate_on_const", ReadData1, 64'hDEAD_BEEF_0000_0001);

        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h1111;
        step();
        WriteData = 64'h2222;
        rd("rdw_before", 7, 7);
        check("rdw_before_const", ReadData2, 64'h1111);
        step();
        RegWrite = 1'b0;
        rd("rdw_after", 7, 7);
        check("rdw_after_const", ReadData1, 64'h2222);

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 99) < 3);
            RegWrite = 1'($urandom);
            WriteRegister = regaddr_t'($urandom);
            WriteData = {$urandom, $urandom};
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : regaddr_t'($urandom);
            rd("rnd_pre", int'(ReadRegister1), int'(regaddr_t'($urandom)));
            step();
            rd("rnd_post", int'(ReadRegister1), int'(ReadRegister2));
        end
        reset = 1'b0;

        RegWrite = 1'b1;
        for (int i = 0; i < ZERO_REG; i++) begin
            WriteRegister = regaddr_t'(i);
            WriteData = {$urandom, $urandom} | 64'h1;
            step();
        end
        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hABCD;
        step();
        reset = 1'b0; RegWrite = 1'b0;
        rd("collide_r3", 3, 3);
        check("collide_r3_const", ReadData1, 64'h0);
        for (int i = 0; i < NREGS_DEFAULT; i++) rd("collide", i, ZERO_REG - i);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
